ace_mem_arbiter: RTL and testbench

ACE_MEM_ARBITER -- requirements
Module: ace_mem_arbiter

---
 rtl/ace_mem_if.sv | 45 ++++
 rtl/ace_mem_arbiter.sv | 98 +++++++++
 tb/tb_ace_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ace_mem_if.sv
// Request/response/memory bundle for ace_mem_arbiter; master = requesters + memory,
// slave = arbiter.
interface ace_mem_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rvalid;
  logic              rd_rready;
  logic [DATA_W-1:0] rd_rdata;

  logic              sn_valid;
  logic              sn_ready;
  logic [ADDR_W-1:0] sn_addr;
  logic              sn_rvalid;
  logic              sn_rready;
  logic [DATA_W-1:0] sn_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_rready,
    output sn_valid, sn_addr, sn_rready, mem_rdata,
    input  wr_ready, rd_ready, rd_rvalid, rd_rdata, sn_ready, sn_rvalid, sn_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_rready,
    input  sn_valid, sn_addr, sn_rready, mem_rdata,
    output wr_ready, rd_ready, rd_rvalid, rd_rdata, sn_ready, sn_rvalid, sn_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ace_mem_arbiter.sv
// Serializes write, read and snoop requesters onto one single-port memory. Snoops win
// unless a streak of them has starved a pending read/write; reads and writes alternate.
module ace_mem_arbiter #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SNOOP_LIMIT = 4
) (
  input logic      clk,
  input logic      rst_n,
  ace_mem_if.slave io_bus
);

  localparam int unsigned CntW = (SNOOP_LIMIT > 0) ? $clog2(SNOOP_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(SNOOP_LIMIT);

  typedef enum logic [1:0] {StIdle, StCap, StResp} state_e;

  state_e            r_state, w_state_d;
  logic              r_src_sn;
  logic              r_last_wr;
  logic [CntW-1:0]   r_streak;
  logic [DATA_W-1:0] r_rd_rdata;
  logic [DATA_W-1:0] r_sn_rdata;

  logic w_idle, w_rw_pend, w_at_limit, w_sn_win, w_wr_win, w_rd_win, w_resp_ack;

  // Arbitration; rst_n gating keeps every ready low while reset is held.
  always_comb begin
    w_idle     = (r_state == StIdle) && rst_n;
    w_rw_pend  = io_bus.rd_valid | io_bus.wr_valid;
    w_at_limit = (r_streak == Limit);
    w_sn_win   = w_idle && io_bus.sn_valid && !(w_at_limit && w_rw_pend);
    w_wr_win   = w_idle && !w_sn_win && io_bus.wr_valid && (!io_bus.rd_valid || !r_last_wr);
    w_rd_win   = w_idle && !w_sn_win && io_bus.rd_valid && (!io_bus.wr_valid || r_last_wr);
    w_resp_ack = r_src_sn ? io_bus.sn_rready : io_bus.rd_rready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_sn_win || w_rd_win) w_state_d = StCap;
      StCap:   w_state_d = StResp;
      StResp:  if (w_resp_ack) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_sn   <= 1'b0;
      r_last_wr  <= 1'b0;
      r_streak   <= '0;
      r_rd_rdata <= '0;
      r_sn_rdata <= '0;
    end else begin
      if (w_sn_win) begin
        r_src_sn <= 1'b1;
        if (w_rw_pend && !w_at_limit) r_streak <= r_streak + CntW'(1);
      end
      if (w_rd_win) begin
        r_src_sn  <= 1'b0;
        r_last_wr <= 1'b0;
        r_streak  <= '0;
      end
      if (w_wr_win) begin
        r_last_wr <= 1'b1;
        r_streak  <= '0;
      end
      if (r_state == StCap) begin
        if (r_src_sn) r_sn_rdata <= io_bus.mem_rdata;
        else          r_rd_rdata <= io_bus.mem_rdata;
      end
    end
  end

  always_comb begin
    io_bus.wr_ready  = w_wr_win;
    io_bus.rd_ready  = w_rd_win;
    io_bus.sn_ready  = w_sn_win;
    io_bus.mem_en    = w_wr_win | w_rd_win | w_sn_win;
    io_bus.mem_we    = w_wr_win;
    io_bus.mem_addr  = w_sn_win ? io_bus.sn_addr : (w_wr_win ? io_bus.wr_addr : io_bus.rd_addr);
    io_bus.mem_wdata = io_bus.wr_data;
    io_bus.rd_rvalid = (r_state == StResp) && !r_src_sn;
    io_bus.sn_rvalid = (r_state == StResp) && r_src_sn;
    io_bus.rd_rdata  = r_rd_rdata;
    io_bus.sn_rdata  = r_sn_rdata;
  end

endmodule

// File: tb/tb_ace_mem_arbiter.sv
// Randomized bench for ace_mem_arbiter: a spec-level arbitration/memory model predicts
// grants and read data; a monitor checks responses against a scoreboard queue.
module tb_ace_mem_arbiter;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 32;
  localparam int          LIM = 4;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic mem_load = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  ace_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ace_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SNOOP_LIMIT(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    return (DW'(i) * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  // Memory device: one-cycle read latency.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  function automatic void check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] exp_sn[$];
  int m_phase;  // 0 idle, 1 capture, 2 response
  bit m_src_sn, m_last_wr;
  int m_streak;
  bit hs_wr, hs_rd, hs_sn;

  task automatic model_step();
    bit rw, g_sn, g_rd, g_wr;
    g_sn = 0; g_rd = 0; g_wr = 0;
    rw = bus.rd_valid || bus.wr_valid;
    if (m_phase == 0) begin
      if (bus.sn_valid && !(m_streak == LIM && rw)) g_sn = 1;
      else if (bus.rd_valid && bus.wr_valid) begin
        if (m_last_wr) g_rd = 1;
        else           g_wr = 1;
      end
      else if (bus.rd_valid) g_rd = 1;
      else if (bus.wr_valid) g_wr = 1;
    end
    check("wr_ready", DW'(bus.wr_ready), DW'(g_wr));
    check("rd_ready", DW'(bus.rd_ready), DW'(g_rd));
    check("sn_ready", DW'(bus.sn_ready), DW'(g_sn));
    check("mem_en", DW'(bus.mem_en), DW'(g_sn | g_rd | g_wr));
    check("mem_we", DW'(bus.mem_we), DW'(g_wr));
    check("rd_rvalid", DW'(bus.rd_rvalid), DW'(m_phase == 2 && !m_src_sn));
    check("sn_rvalid", DW'(bus.sn_rvalid), DW'(m_phase == 2 && m_src_sn));
    if (g_sn) check("mem_addr_sn", DW'(bus.mem_addr), DW'(bus.sn_addr));
    if (g_rd) check("mem_addr_rd", DW'(bus.mem_addr), DW'(bus.rd_addr));
    if (g_wr) begin
      check("mem_addr_wr", DW'(bus.mem_addr), DW'(bus.wr_addr));
      check("mem_wdata", bus.mem_wdata, bus.wr_data);
    end
    hs_sn = g_sn; hs_rd = g_rd; hs_wr = g_wr;
    if (g_sn) begin
      exp_sn.push_back(ref_mem[bus.sn_addr]);
      m_src_sn = 1;
      if (rw && m_streak < LIM) m_streak++;
      m_phase = 1;
    end else if (g_rd) begin
      exp_rd.push_back(ref_mem[bus.rd_addr]);
      m_src_sn = 0; m_last_wr = 0; m_streak = 0;
      m_phase = 1;
    end else if (g_wr) begin
      ref_mem[bus.wr_addr] = bus.wr_data;
      m_last_wr = 1; m_streak = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && (m_src_sn ? bus.sn_rready : bus.rd_rready)) begin
      m_phase = 0;
    end
  endtask

  // Scoreboard monitor
  logic [DW-1:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_rvalid && bus.rd_rready) begin
        if (exp_rd.size() == 0) check("rd_resp_unexpected", 1, 0);
        else begin
          mon_exp = exp_rd.pop_front();
          check("rd_rdata", bus.rd_rdata, mon_exp);
        end
      end
      if (bus.sn_rvalid && bus.sn_rready) begin
        if (exp_sn.size() == 0) check("sn_resp_unexpected", 1, 0);
        else begin
          mon_exp = exp_sn.pop_front();
          check("sn_rdata", bus.sn_rdata, mon_exp);
        end
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = ($urandom_range(0, 9) == 0) ? AW'(63) : AW'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic drive(int pw, int pr, int ps, int prr);
    if (hs_wr || !bus.wr_valid) begin
      bus.wr_valid = (int'($urandom_range(0, 99)) < pw);
      bus.wr_addr  = rand_addr();
      bus.wr_data  = $urandom;
    end
    if (hs_rd || !bus.rd_valid) begin
      bus.rd_valid = (int'($urandom_range(0, 99)) < pr);
      bus.rd_addr  = rand_addr();
    end
    if (hs_sn || !bus.sn_valid) begin
      bus.sn_valid = (int'($urandom_range(0, 99)) < ps);
      bus.sn_addr  = rand_addr();
    end
    bus.rd_rready = (int'($urandom_range(0, 99)) < prr);
    bus.sn_rready = (int'($urandom_range(0, 99)) < prr);
    hs_wr = 0; hs_rd = 0; hs_sn = 0;
  endtask

  task automatic run_cycle(int pw, int pr, int ps, int prr);
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    drive(pw, pr, ps, prr);
  endtask

  task automatic reset_outputs_check(string tag);
    check({tag, "_wr_ready"}, DW'(bus.wr_ready), 0);
    check({tag, "_rd_ready"}, DW'(bus.rd_ready), 0);
    check({tag, "_sn_ready"}, DW'(bus.sn_ready), 0);
    check({tag, "_mem_en"}, DW'(bus.mem_en), 0);
    check({tag, "_mem_we"}, DW'(bus.mem_we), 0);
    check({tag, "_rd_rvalid"}, DW'(bus.rd_rvalid), 0);
    check({tag, "_sn_rvalid"}, DW'(bus.sn_rvalid), 0);
    check({tag, "_rd_rdata"}, bus.rd_rdata, 0);
    check({tag, "_sn_rdata"}, bus.sn_rdata, 0);
  endtask

  // {write %, read %, snoop %, rready %} per segment
  int seg [6][4] = '{'{100, 100, 0, 100}, '{0, 100, 100, 100}, '{100, 100, 100, 60},
                     '{50, 50, 50, 30}, '{30, 30, 30, 100}, '{0, 100, 0, 10}};

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    m_phase = 0; m_src_sn = 0; m_last_wr = 0; m_streak = 0;
    hs_wr = 0; hs_rd = 0; hs_sn = 0;
    bus.wr_valid = 1; bus.rd_valid = 1; bus.sn_valid = 1;
    bus.wr_addr = rand_addr(); bus.rd_addr = rand_addr(); bus.sn_addr = rand_addr();
    bus.wr_data = $urandom;
    bus.rd_rready = 0; bus.sn_rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs_check("reset");
    @(posedge clk);
    #1;
    rst_n = 1; mem_load = 0;

    for (int s = 0; s < 6; s++) begin
      repeat (400) run_cycle(seg[s][0], seg[s][1], seg[s][2], seg[s][3]);
    end

    // Reset pulses landing in the response phase
    for (int k = 0; k < 3; k++) begin
      int guard;
      guard = 0;
      while (m_phase != 2 && guard < 100) begin
        run_cycle(50, 80, 50, 20);
        guard++;
      end
      if (m_phase != 2) check("resp_phase_reached", 0, 1);
      else begin
        #2 rst_n = 0;
        #1;
        reset_outputs_check("resp_reset");
        m_phase = 0; m_src_sn = 0; m_last_wr = 0; m_streak = 0;
        exp_rd.delete(); exp_sn.delete();
        @(posedge clk);
        #1 rst_n = 1;
      end
      repeat (50) run_cycle(50, 50, 50, 50);
    end

    repeat (60) run_cycle(0, 0, 0, 100);
    check("rd_queue_drained", DW'(exp_rd.size()), 0);
    check("sn_queue_drained", DW'(exp_sn.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
